// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: FSM states, accumulator
// width rule and signed saturation helper reused by future conv arrays.
// Optional feature macro used by this slice: CONV_RELU_EN (see conv_sat_relu).
package conv_pkg;

  typedef enum logic [0:0] {
    ST_ACC,
    ST_OUT
  } state_t;

  // Width of the generic saturation helper; wide enough for any practical ACC_W.
  localparam int SAT_W = 64;

  // Accumulator width: full signed product plus growth for NTAP additions.
  function automatic int acc_width(input int data_w, input int ntap);
    return 2 * data_w + $clog2(ntap);
  endfunction

  // Clamp a signed value to the range of an out_w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] acc,
                                                   input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/conv_sat_relu.sv
// Combinational result stage: optional ReLU followed by signed saturation,
// ACC_W bits in, OUT_W bits out.
// Define CONV_RELU_EN to clamp negative sums to zero before saturation.
module conv_sat_relu #(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] sat_out
);
  import conv_pkg::*;

  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] clamped;

  // Sign-extend, optionally rectify, then clamp into the output range.
  always_comb begin
    wide = SAT_W'(acc_in);
`ifdef CONV_RELU_EN
    if (wide < 64'sd0) begin
      wide = 64'sd0;
    end
`else
    wide = wide;
`endif
    clamped = sat_s(wide, OUT_W);
    sat_out = OUT_W'(clamped);
  end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential KxK convolution MAC: programmable signed kernel, one tap per
// accepted pixel, one saturated result per window on a valid/ready port.
// Build option CONV_RELU_EN (handled inside conv_sat_relu) rectifies the sum.
module conv_window_mac #(
  parameter int KSIZE  = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 w_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]       w_addr,
  input  logic signed [DATA_W-1:0]             w_data,
  input  logic                                 px_valid,
  output logic                                 px_ready,
  input  logic signed [DATA_W-1:0]             px_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [OUT_W-1:0]              out_data,
  output logic                                 busy
);
  import conv_pkg::*;

  localparam int NTAP   = KSIZE * KSIZE;
  localparam int AW     = $clog2(NTAP);
  localparam int ACC_W  = acc_width(DATA_W, NTAP);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAP - 1);
  localparam logic [AW:0]   NTAP_EXT = (AW + 1)'(NTAP);

  state_t                    state;
  logic [AW-1:0]             tap_idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [PROD_W-1:0]  prod;
  logic signed [OUT_W-1:0]   sat_value;
  logic signed [DATA_W-1:0]  weights [NTAP];
  logic                      px_fire;
  logic                      out_fire;

  assign px_ready = (state == ST_ACC) && !rst;
  assign busy     = (tap_idx != '0) || (state == ST_OUT);
  assign px_fire  = px_valid && px_ready;
  assign out_fire = out_valid && out_ready;

  // Current tap product and the running sum it produces (restarts at tap 0).
  always_comb begin
    prod     = PROD_W'(weights[tap_idx]) * PROD_W'(px_data);
    acc_next = ((tap_idx == '0) ? ACC_W'(0) : acc) + ACC_W'(prod);
  end

  conv_sat_relu #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .acc_in (acc_next),
    .sat_out(sat_value)
  );

  // Kernel storage: writes land only between windows so a window sees one kernel.
  always_ff @(posedge clk) begin
    if (w_we && !busy && ({1'b0, w_addr} < NTAP_EXT)) begin
      weights[w_addr] <= w_data;
    end
  end

  // Window FSM: accumulate NTAP taps, then hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      tap_idx   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (px_fire) begin
            acc <= acc_next;
            if (tap_idx == LAST_TAP) begin
              tap_idx   <= '0;
              state     <= ST_OUT;
              out_valid <= 1'b1;
              out_data  <= sat_value;
            end else begin
              tap_idx <= tap_idx + AW'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            state     <= ST_ACC;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Self-checking bench for conv_window_mac with a plain-arithmetic window model.
// Honours CONV_RELU_EN in its model when the build defines it.
module tb_conv_window_mac;

  localparam int NTAP = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_we;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic              px_valid;
  logic              px_ready;
  logic signed [7:0] px_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int mw[NTAP];

  always #5 clk = ~clk;

  conv_window_mac #(
    .KSIZE (3),
    .DATA_W(8),
    .OUT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_data  (px_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window result from the kernel model: dot product, optional ReLU, clamp.
  function automatic int model(input int px[NTAP]);
    int s;
    s = 0;
    for (int i = 0; i < NTAP; i++) s += mw[i] * px[i];
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic writeWeight(input int addr, input int data);
    checkOutput("wr.busy", busy, 0);
    w_we   = 1'b1;
    w_addr = 4'(addr);
    w_data = 8'(data);
    step();
    w_we = 1'b0;
    mw[addr] = data;
  endtask

  task automatic writeAll(input int v);
    for (int i = 0; i < NTAP; i++) writeWeight(i, v);
  endtask

  // Feed one window (optional bubbles, optional weight write at tap wr_tap),
  // then hold the result for 'hold' cycles before accepting it.
  task automatic applyStimulus(input string tag, input int px[NTAP], input int max_bubble,
                               input int hold, input int wr_tap, input int wr_addr,
                               input int wr_data);
    int exp_val;
    int nb;
    exp_val   = model(px);
    out_ready = 1'b0;
    for (int i = 0; i < NTAP; i++) begin
      nb = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
      repeat (nb) begin
        px_valid = 1'b0;
        px_data  = 8'($urandom);
        step();
      end
      checkOutput({tag, ".px_ready"}, px_ready, 1);
      px_valid = 1'b1;
      px_data  = 8'(px[i]);
      if (i == wr_tap) begin
        w_we   = 1'b1;
        w_addr = 4'(wr_addr);
        w_data = 8'(wr_data);
      end
      step();
      px_valid = 1'b0;
      w_we     = 1'b0;
    end
    if (wr_tap == 0) mw[wr_addr] = wr_data;
    checkOutput({tag, ".out_valid"}, out_valid, 1);
    checkOutput({tag, ".out_data"}, out_data, exp_val);
    checkOutput({tag, ".px_ready_out"}, px_ready, 0);
    checkOutput({tag, ".busy_out"}, busy, 1);
    repeat (hold) begin
      step();
      checkOutput({tag, ".hold_valid"}, out_valid, 1);
      checkOutput({tag, ".hold_data"}, out_data, exp_val);
      checkOutput({tag, ".hold_px_ready"}, px_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, ".done_valid"}, out_valid, 0);
    checkOutput({tag, ".done_px_ready"}, px_ready, 1);
    checkOutput({tag, ".done_busy"}, busy, 0);
  endtask

  initial begin
    int px[NTAP];
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    px_valid = 1'b0; px_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NTAP; i++) mw[i] = 0;

    // Reset state
    step(); step();
    checkOutput("rst.px_ready", px_ready, 0);
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.out_data", out_data, 0);
    checkOutput("rst.busy", busy, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release.px_ready", px_ready, 1);

    // Ones kernel, pixels 1..9 back-to-back
    writeAll(1);
    for (int i = 0; i < NTAP; i++) px[i] = i + 1;
    applyStimulus("ones_seq", px, 0, 0, -1, 0, 0);

    // Negative kernel
    writeAll(-1);
    applyStimulus("neg_seq", px, 0, 0, -1, 0, 0);

    // Positive and negative saturation
    writeAll(127);
    for (int i = 0; i < NTAP; i++) px[i] = 127;
    applyStimulus("sat_pos", px, 0, 0, -1, 0, 0);
    writeAll(-128);
    applyStimulus("sat_neg", px, 0, 0, -1, 0, 0);

    // Output back-pressure, then a plain ones window
    writeAll(1);
    for (int i = 0; i < NTAP; i++) px[i] = int'($urandom_range(0, 255)) - 128;
    applyStimulus("stall", px, 0, 5, -1, 0, 0);
    for (int i = 0; i < NTAP; i++) px[i] = 1;
    applyStimulus("after_stall", px, 0, 0, -1, 0, 0);

    // Reset after 4 accepted taps abandons the window
    for (int i = 0; i < 4; i++) begin
      px_valid = 1'b1;
      px_data  = 8'sd3;
      step();
    end
    px_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst.px_ready", px_ready, 0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("midrst.out_valid", out_valid, 0);
    checkOutput("midrst.busy", busy, 0);
    checkOutput("midrst.out_data", out_data, 0);
    repeat (NTAP) begin
      step();
      checkOutput("midrst.idle_valid", out_valid, 0);
    end
    for (int i = 0; i < NTAP; i++) px[i] = 2;
    applyStimulus("after_rst", px, 0, 0, -1, 0, 0);

    // Weight write while busy is ignored; same write while idle takes effect
    for (int i = 0; i < NTAP; i++) px[i] = 1;
    applyStimulus("busy_wr", px, 0, 0, 3, 0, 5);
    writeWeight(0, 5);
    applyStimulus("idle_wr", px, 0, 0, -1, 0, 0);
    // Write alongside the first pixel: old weight used, new one next window
    applyStimulus("same_cycle_wr", px, 0, 0, 0, 0, 2);
    applyStimulus("after_same_cycle", px, 0, 0, -1, 0, 0);

    // Randomized kernels, pixels, bubbles and back-pressure
    for (int w = 0; w < 12; w++) begin
      for (int i = 0; i < NTAP; i++) begin
        if ($urandom_range(0, 1) == 1) writeWeight(i, int'($urandom_range(0, 255)) - 128);
      end
      for (int i = 0; i < NTAP; i++) px[i] = int'($urandom_range(0, 255)) - 128;
      applyStimulus($sformatf("rand%0d", w), px, 2, int'($urandom_range(0, 3)), -1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
